// File: rtl/jr_return_stack.sv
// Circular return-address stack that observes jal/jr in the single-cycle MIPS datapath
// and reports prediction hit/miss pulses plus sticky overflow/underflow flags.
module jr_return_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             pop,
    input  logic [WIDTH-1:0] actual_addr,
    output logic [WIDTH-1:0] top_addr,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             pred_hit,
    output logic             pred_miss,
    output logic             overflow,
    output logic             underflow
);

    // Handshake: push/pop are single-cycle qualifiers with no ready; every asserted
    // request is consumed on the next rising edge unless flush is also high.

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] top;
    logic             hit_cond;
    logic             mem_we;
    logic [PTR_W-1:0] mem_wa;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign top_addr = empty ? '0 : mem[top];
    assign hit_cond = !empty && (top_addr == actual_addr);

    // Replace-top writes in place; every other push (including push+pop while empty)
    // writes the slot above the current top.
    assign mem_we = push && !flush;
    assign mem_wa = (pop && !empty) ? top : top + 1'b1;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= push_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top       <= '0;
            count     <= '0;
            pred_hit  <= 1'b0;
            pred_miss <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            top       <= '0;
            count     <= '0;
            pred_hit  <= 1'b0;
            pred_miss <= 1'b0;
        end else if (push && pop) begin
            pred_hit  <= hit_cond;
            pred_miss <= !hit_cond;
            if (empty) begin
                top       <= top + 1'b1;
                count     <= count + 1'b1;
                underflow <= 1'b1;
            end
        end else if (push) begin
            pred_hit  <= 1'b0;
            pred_miss <= 1'b0;
            top       <= top + 1'b1;
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                pred_hit  <= hit_cond;
                pred_miss <= !hit_cond;
                top       <= top - 1'b1;
                count     <= count - 1'b1;
            end else begin
                pred_hit  <= 1'b0;
                pred_miss <= 1'b1;
                underflow <= 1'b1;
            end
        end else begin
            pred_hit  <= 1'b0;
            pred_miss <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jr_return_stack.sv
// Bench for jr_return_stack: directed scenarios plus random jal/jr/flush traffic
// checked against a queue-based model of the return stack.
module tb_jr_return_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             push;
    logic [WIDTH-1:0] push_addr;
    logic             pop;
    logic [WIDTH-1:0] actual_addr;
    logic [WIDTH-1:0] top_addr;
    logic             empty;
    logic             full;
    logic [PTR_W:0]   count;
    logic             pred_hit;
    logic             pred_miss;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: newest address at the back of the queue
    logic [WIDTH-1:0] exp_q[$];
    logic             m_hit, m_miss, m_ovf, m_unf;

    jr_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .push_addr(push_addr),
        .pop(pop), .actual_addr(actual_addr), .top_addr(top_addr), .empty(empty),
        .full(full), .count(count), .pred_hit(pred_hit), .pred_miss(pred_miss),
        .overflow(overflow), .underflow(underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_top();
        return (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : '0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_hit = 1'b0; m_miss = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step(input logic f, input logic pu, input logic po,
                              input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] aa);
        m_hit = 1'b0;
        m_miss = 1'b0;
        if (f) begin
            exp_q.delete();
        end else if (pu && po) begin
            if (exp_q.size() > 0) begin
                m_hit  = (model_top() == aa);
                m_miss = !m_hit;
                exp_q[exp_q.size()-1] = pa;
            end else begin
                m_miss = 1'b1;
                m_unf  = 1'b1;
                exp_q.push_back(pa);
            end
        end else if (pu) begin
            if (exp_q.size() == DEPTH) begin
                void'(exp_q.pop_front());
                m_ovf = 1'b1;
            end
            exp_q.push_back(pa);
        end else if (po) begin
            if (exp_q.size() > 0) begin
                m_hit  = (model_top() == aa);
                m_miss = !m_hit;
                void'(exp_q.pop_back());
            end else begin
                m_miss = 1'b1;
                m_unf  = 1'b1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_top"}, 64'(top_addr), 64'(model_top()));
        check({tag, "_count"}, 64'(count), 64'(exp_q.size()));
        check({tag, "_empty"}, 64'(empty), 64'(exp_q.size() == 0));
        check({tag, "_full"}, 64'(full), 64'(exp_q.size() == DEPTH));
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_hit"}, 64'(pred_hit), 64'(m_hit));
        check({tag, "_miss"}, 64'(pred_miss), 64'(m_miss));
        check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_unf"}, 64'(underflow), 64'(m_unf));
    endtask

    // driver: called at posedge+1, leaves at the following posedge+1
    task automatic step(input string tag, input logic f, input logic pu, input logic po,
                        input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] aa);
        flush = f; push = pu; pop = po; push_addr = pa; actual_addr = aa;
        #1;
        check_state({tag, "_pre"});
        model_step(f, pu, po, pa, aa);
        @(posedge clk);
        #1;
        flush = 1'b0; push = 1'b0; pop = 1'b0;
        check_flags(tag);
        check_state(tag);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] pa);
        step("push", 1'b0, 1'b1, 1'b0, pa, '0);
    endtask

    task automatic do_pop(input logic [WIDTH-1:0] aa);
        step("pop", 1'b0, 1'b0, 1'b1, '0, aa);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0;
        push_addr = '0; actual_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("rst_hold");
        check_flags("rst_hold");
        apply_reset();

        // asynchronous reset mid-cycle with three entries
        do_push(32'h10); do_push(32'h20); do_push(32'h30);
        check("rst_pre_count", 64'(count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_empty", 64'(empty), 64'd1);
        check("async_rst_top", 64'(top_addr), 64'd0);
        check_flags("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // push/pop ordering
        do_push(32'h0040_0010);
        do_push(32'h0040_0020);
        do_pop(32'h0040_0020);
        check("order_hit", 64'(pred_hit), 64'd1);
        check("order_top", 64'(top_addr), 64'h0040_0010);
        do_pop(32'h0040_0099);
        check("order_miss", 64'(pred_miss), 64'd1);
        check("order_empty", 64'(empty), 64'd1);
        step("idle", 1'b0, 1'b0, 1'b0, '0, '0);
        check("pulse_len", 64'(pred_miss), 64'd0);

        // overflow wrap
        for (int i = 1; i <= 9; i++) do_push(32'(i) * 32'h100);
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_top", 64'(top_addr), 64'h900);
        for (int i = 9; i >= 2; i--) begin
            do_pop(32'(i) * 32'h100);
            check("ovf_pop_hit", 64'(pred_hit), 64'd1);
        end
        check("ovf_drained", 64'(empty), 64'd1);

        // underflow
        apply_reset();
        do_pop(32'h1234);
        check("unf_miss", 64'(pred_miss), 64'd1);
        check("unf_flag", 64'(underflow), 64'd1);
        step("unf_idle", 1'b0, 1'b0, 1'b0, '0, '0);
        check("unf_sticky", 64'(underflow), 64'd1);
        do_push(32'h40);
        check("unf_push_top", 64'(top_addr), 64'h40);

        // simultaneous push and pop replaces the top
        apply_reset();
        do_push(32'h200); do_push(32'h300);
        step("replace", 1'b0, 1'b1, 1'b1, 32'h500, 32'h300);
        check("replace_hit", 64'(pred_hit), 64'd1);
        check("replace_top", 64'(top_addr), 64'h500);
        check("replace_count", 64'(count), 64'd2);
        apply_reset();
        step("replace_empty", 1'b0, 1'b1, 1'b1, 32'h600, 32'h600);

        // flush keeps sticky flags and ignores a concurrent push
        apply_reset();
        for (int i = 1; i <= 9; i++) do_push(32'(i) * 32'h10);
        for (int i = 0; i < 3; i++) do_pop(32'h0);
        check("flush_pre_count", 64'(count), 64'd5);
        step("flush", 1'b1, 1'b1, 1'b0, 32'hABC, '0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_ovf_kept", 64'(overflow), 64'd1);

        // random traffic
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic f, pu, po;
            logic [WIDTH-1:0] pa, aa;
            r  = $urandom_range(0, 99);
            f  = (r < 3);
            pu = ($urandom_range(0, 99) < 50);
            po = ($urandom_range(0, 99) < 45);
            pa = 32'($urandom_range(0, 255)) << 2;
            aa = ($urandom_range(0, 1) == 1) ? model_top() : 32'($urandom_range(0, 255)) << 2;
            step("rand", f, pu, po, pa, aa);
            if (pred_hit && pred_miss) check("rand_excl", 64'd1, 64'd0);
            if ($urandom_range(0, 199) == 0) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
